mem_access_unit: RTL

Memory-stage data access unit for the pipelined ARMv8 core. Takes the load/store request from the EX/MEM pipeline register, runs a req/ack transaction on the external data-memory bus, stalls the pipeline until the access completes, and supplies the 64-bit load result to the MEM/WB register's read-data input.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: runs one req/ack data-bus transaction per access and stalls the pipeline until it completes.
// Optional bus timeout watchdog is compiled in when MEM_TIMEOUT_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a load/store from EX/MEM
// BUSY  | bus_req held high, waiting for bus_ack (or timeout)
// DONE  | one unstalled cycle so the instruction advances into MEM/WB
module mem_access_unit #(
   parameter int unsigned ADDR_W         = 64,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              stall,
   output logic              align_fault,
   output logic              bus_fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack
);

   if (DATA_W != 64 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("mem_access_unit: DATA_W must be 64 and TIMEOUT_CYCLES nonzero");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic request;
   logic aligned;
   logic timeout;

   assign request = mem_read | mem_write;
   assign aligned = (address[2:0] == 3'b000);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] busy_cnt;

   // Counter holds the number of BUSY cycles already spent without ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_cnt <= '0;
      end else if (state != BUSY) begin
         busy_cnt <= '0;
      end else if (!bus_ack) begin
         busy_cnt <= busy_cnt + CNT_W'(1);
      end
   end

   assign timeout = (state == BUSY) && !bus_ack && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         bus_fault <= 1'b0;
      end else if (timeout) begin
         bus_fault <= 1'b1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign bus_fault = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (request) begin
               state_nxt = aligned ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (bus_ack || timeout) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if ((state == IDLE && request && aligned) || state == BUSY) begin
         stall = 1'b1;
      end
   end

   // Bus-side registers and the load result; requests seen in DONE are deliberately dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_data   <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         align_fault <= 1'b0;
      end else begin
         align_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (request) begin
                  if (aligned) begin
                     bus_req   <= 1'b1;
                     bus_we    <= mem_write;
                     bus_addr  <= address;
                     bus_wdata <= write_data;
                  end else begin
                     align_fault <= 1'b1;
                     read_data   <= '0;
                  end
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     read_data <= bus_rdata;
                  end
               end else if (timeout) begin
                  bus_req   <= 1'b0;
                  read_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
